channel_in_lane_split: RTL and testbench



---
 rtl/channel_in_lane_split.sv | 88 ++++++++
 tb/tb_channel_in_lane_split.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/channel_in_lane_split.sv
// Splits a word of COMPUTE_CHANNEL_IN_NUM packed channel-in lanes into one output
// beat per lane, lane 0 first, with valid/ready on both sides and no bubbles.
`ifndef PICTURE_NUM
`define PICTURE_NUM 1
`endif
`ifndef WIDTH_DATA_OUT
`define WIDTH_DATA_OUT 8
`endif

module channel_in_lane_split #(
  parameter int COMPUTE_CHANNEL_IN_NUM = 2,
  localparam int LANE_W = `PICTURE_NUM * `WIDTH_DATA_OUT * 2,
  localparam int CNT_W  = ($clog2(COMPUTE_CHANNEL_IN_NUM) > 1) ? $clog2(COMPUTE_CHANNEL_IN_NUM) : 1
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     s_valid,
  output logic                                     s_ready,
  input  logic [COMPUTE_CHANNEL_IN_NUM*LANE_W-1:0] s_data,
  input  logic                                     s_last,
  output logic                                     m_valid,
  input  logic                                     m_ready,
  output logic [LANE_W-1:0]                        m_data,
  output logic [CNT_W-1:0]                         m_lane,
  output logic                                     m_last
);

  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(COMPUTE_CHANNEL_IN_NUM - 1);

  typedef enum logic {IDLE, SEND} state_e;

  state_e                                        state_q, state_d;
  logic [COMPUTE_CHANNEL_IN_NUM-1:0][LANE_W-1:0] holdData_q, holdData_d;
  logic                                          holdLast_q, holdLast_d;
  logic [CNT_W-1:0]                              cnt_q, cnt_d;

  logic holdValid;
  logic onLastLane;
  logic inXfer;
  logic outXfer;

  assign holdValid  = (state_q == SEND);
  assign onLastLane = (cnt_q == LAST_LANE);

  // Accept a new word while the final lane of the current one leaves, so words stream back-to-back.
  assign s_ready = !holdValid || (m_ready && onLastLane);
  assign inXfer  = s_valid && s_ready;
  assign outXfer = holdValid && m_ready;

  assign m_valid = holdValid;
  assign m_data  = holdData_q[cnt_q];
  assign m_lane  = cnt_q;
  assign m_last  = holdLast_q && onLastLane;

  always_comb begin
    state_d    = state_q;
    holdData_d = holdData_q;
    holdLast_d = holdLast_q;
    cnt_d      = cnt_q;
    if (inXfer) begin
      state_d    = SEND;
      holdData_d = s_data;
      holdLast_d = s_last;
      cnt_d      = '0;
    end else if (outXfer) begin
      if (onLastLane) begin
        state_d = IDLE;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      holdData_q <= '0;
      holdLast_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      holdData_q <= holdData_d;
      holdLast_q <= holdLast_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_channel_in_lane_split.sv
// Scoreboard bench for channel_in_lane_split: directed words are pushed as expected
// lanes, and a negedge monitor pops and compares every accepted output beat.
`ifndef PICTURE_NUM
`define PICTURE_NUM 1
`endif
`ifndef WIDTH_DATA_OUT
`define WIDTH_DATA_OUT 8
`endif

module tb_channel_in_lane_split;

  localparam int LW = `PICTURE_NUM * `WIDTH_DATA_OUT * 2;

  typedef struct packed {
    logic [LW-1:0] data;
    logic          lane;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [2*LW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [LW-1:0] m_data;
  logic          m_lane;
  logic          m_last;

  logic          s_valid4 = 1'b0;
  logic          s_ready4;
  logic [4*LW-1:0] s_data4 = '0;
  logic          s_last4 = 1'b0;
  logic          m_valid4;
  logic          m_ready4 = 1'b1;
  logic [LW-1:0] m_data4;
  logic [1:0]    m_lane4;
  logic          m_last4;

  int errors = 0;
  int checks = 0;
  int cycleCnt = 0;
  int readyMode = 0;
  int popCount = 0;
  int lastPopCycle = 0;
  int mLastSeen = 0;
  int sLastSent = 0;
  beat_t expQ[$];
  logic readyLog[$];

  channel_in_lane_split #(.COMPUTE_CHANNEL_IN_NUM(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_lane(m_lane), .m_last(m_last)
  );

  channel_in_lane_split #(.COMPUTE_CHANNEL_IN_NUM(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid4), .s_ready(s_ready4), .s_data(s_data4), .s_last(s_last4),
    .m_valid(m_valid4), .m_ready(m_ready4), .m_data(m_data4), .m_lane(m_lane4), .m_last(m_last4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Downstream ready: always on, held off, or random stalls.
  always @(posedge clk) begin
    #1;
    case (readyMode)
      0:       m_ready = 1'b1;
      1:       m_ready = 1'b0;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a stalled beat must hold still; an accepted beat must match the scoreboard head.
  logic  holdPending = 1'b0;
  beat_t heldBeat;
  always @(negedge clk) begin
    beat_t seen;
    beat_t exp;
    seen = '{data: m_data, lane: m_lane, last: m_last};
    if (rst_n && m_valid) begin
      if (holdPending) checkOutput("stall_stable", 64'(seen), 64'(heldBeat));
      if (m_ready) begin
        holdPending = 1'b0;
        if (expQ.size() == 0) begin
          checkOutput("unexpected_beat", 64'(seen), 64'(0));
        end else begin
          exp = expQ.pop_front();
          checkOutput("beat", 64'(seen), 64'(exp));
        end
        popCount++;
        lastPopCycle = cycleCnt;
        if (m_last) mLastSeen++;
      end else begin
        holdPending = 1'b1;
        heldBeat    = seen;
      end
    end else begin
      holdPending = 1'b0;
    end
  end

  task automatic applyStimulus(input logic [2*LW-1:0] data, input logic last,
                               output int acceptCycle, output int tries);
    logic accepted;
    accepted    = 1'b0;
    tries       = 0;
    acceptCycle = 0;
    s_valid = 1'b1;
    s_data  = data;
    s_last  = last;
    while (!accepted && tries < 100) begin
      @(negedge clk);
      tries++;
      readyLog.push_back(s_ready);
      if (s_ready) begin
        accepted    = 1'b1;
        acceptCycle = cycleCnt;
        expQ.push_back('{data: data[LW-1:0],    lane: 1'b0, last: 1'b0});
        expQ.push_back('{data: data[2*LW-1:LW], lane: 1'b1, last: last});
        if (last) sLastSent++;
      end
      @(posedge clk); #1;
    end
    if (!accepted) checkOutput("accept_timeout", 64'(tries), 64'(0));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_timeout", 64'(expQ.size()), 64'(0));
    @(posedge clk); #1;
  endtask

  task automatic checkIdle(input string name);
    @(negedge clk);
    checkOutput({name, "_m_valid"}, 64'(m_valid), 64'(0));
    checkOutput({name, "_s_ready"}, 64'(s_ready), 64'(1));
  endtask

  initial begin
    int ac, tr, ac0;
    logic expReady [6];
    expReady = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    // Reset values
    @(negedge clk);
    checkOutput("rst_m_valid", 64'(m_valid), 64'(0));
    checkOutput("rst_m_last",  64'(m_last),  64'(0));
    checkOutput("rst_m_lane",  64'(m_lane),  64'(0));
    checkOutput("rst_m_data",  64'(m_data),  64'(0));
    checkOutput("rst_s_ready", 64'(s_ready), 64'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single word B:A with last, first lane one cycle after acceptance
    applyStimulus({16'(LW'('hB)), 16'(LW'('hA))}, 1'b1, ac, tr);
    checkOutput("first_accept_tries", 64'(tr), 64'(1));
    s_valid = 1'b0;
    @(negedge clk);
    checkOutput("single_l0_valid", 64'(m_valid), 64'(1));
    checkOutput("single_l0_lane",  64'(m_lane),  64'(0));
    checkOutput("single_l0_data",  64'(m_data),  64'(LW'('hA)));
    checkOutput("single_l0_last",  64'(m_last),  64'(0));
    @(negedge clk);
    checkOutput("single_l1_lane",  64'(m_lane),  64'(1));
    checkOutput("single_l1_data",  64'(m_data),  64'(LW'('hB)));
    checkOutput("single_l1_last",  64'(m_last),  64'(1));
    @(negedge clk);
    checkOutput("single_done_valid", 64'(m_valid), 64'(0));
    drain();

    // Streaming three words with s_valid held high
    readyLog.delete();
    applyStimulus({LW'(1), LW'(0)}, 1'b0, ac0, tr);
    applyStimulus({LW'(3), LW'(2)}, 1'b0, ac, tr);
    applyStimulus({LW'(5), LW'(4)}, 1'b1, ac, tr);
    s_valid = 1'b0;
    @(negedge clk);
    readyLog.push_back(s_ready);
    checkOutput("stream_ready_len", 64'(readyLog.size()), 64'(6));
    for (int i = 0; i < 6 && i < readyLog.size(); i++)
      checkOutput($sformatf("stream_ready_%0d", i), 64'(readyLog[i]), 64'(expReady[i]));
    drain();
    checkOutput("stream_no_bubble", 64'(lastPopCycle - ac0), 64'(6));

    // Backpressure: lane 0 held for three cycles
    readyMode = 1;
    @(posedge clk); #1;
    applyStimulus({LW'('hB), LW'('hA)}, 1'b0, ac, tr);
    s_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp_data",    64'(m_data),  64'(LW'('hA)));
      checkOutput("bp_lane",    64'(m_lane),  64'(0));
      checkOutput("bp_s_ready", 64'(s_ready), 64'(0));
    end
    readyMode = 0;
    drain();

    // Reset after lane 0 of D:C leaves: lane D must never appear
    applyStimulus({LW'('hD), LW'('hC)}, 1'b0, ac, tr);
    s_valid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    checkOutput("midrst_pending", 64'(expQ.size()), 64'(1));
    expQ.delete();
    checkIdle("midrst_during");
    @(negedge clk);
    checkOutput("midrst_m_lane", 64'(m_lane), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    checkIdle("midrst_after");
    checkIdle("midrst_after2");
    @(posedge clk); #1;
    applyStimulus({LW'('h2), LW'('h1)}, 1'b1, ac, tr);
    checkOutput("post_rst_first_accept", 64'(tr), 64'(1));
    s_valid = 1'b0;
    drain();

    // Random stalls on both sides
    readyMode = 2;
    for (int w = 0; w < 1000; w++) begin
      int gap;
      gap = $urandom_range(0, 2);
      if (gap != 0) begin
        s_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
      end
      applyStimulus({LW'($urandom), LW'($urandom)}, 1'($urandom_range(0, 1)), ac, tr);
    end
    s_valid = 1'b0;
    drain();
    readyMode = 0;
    checkOutput("last_count", 64'(mLastSeen), 64'(sLastSent));

    // Four-lane instance
    s_valid4 = 1'b1;
    s_data4  = {LW'(3), LW'(2), LW'(1), LW'(0)};
    s_last4  = 1'b1;
    @(negedge clk);
    checkOutput("n4_s_ready", 64'(s_ready4), 64'(1));
    @(posedge clk); #1;
    s_valid4 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput($sformatf("n4_valid_%0d", k), 64'(m_valid4), 64'(1));
      checkOutput($sformatf("n4_lane_%0d", k),  64'(m_lane4),  64'(k));
      checkOutput($sformatf("n4_data_%0d", k),  64'(m_data4),  64'(k));
      checkOutput($sformatf("n4_last_%0d", k),  64'(m_last4),  64'(k == 3));
    end
    @(negedge clk);
    checkOutput("n4_done_valid", 64'(m_valid4), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
